// File: rtl/rv_tag_reorder_queue.sv
// Tag reorder queue: tags are issued in order, responses land out of order,
// and completed slots retire strictly in allocation order.
module rv_tag_reorder_queue #(
    parameter int DATAW = 32,
    parameter int SIZE  = 8,
    parameter int ADDRW = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    output logic [ADDRW-1:0] alloc_tag,
    input  logic             rsp_valid,
    input  logic [ADDRW-1:0] rsp_tag,
    input  logic [DATAW-1:0] rsp_data,
    output logic             out_valid,
    output logic [ADDRW-1:0] out_tag,
    output logic [DATAW-1:0] out_data,
    input  logic             out_ready,
    output logic             empty,
    output logic             full,
    output logic [ADDRW:0]   count
);

    localparam logic [ADDRW:0]   FULL_CNT = (ADDRW + 1)'(SIZE);
    localparam logic [ADDRW:0]   CNT_ONE  = (ADDRW + 1)'(1);
    localparam logic [ADDRW-1:0] PTR_ONE  = ADDRW'(1);

    logic [ADDRW-1:0] head;
    logic [ADDRW-1:0] tail;
    logic [ADDRW:0]   count_q;
    logic [SIZE-1:0]  inflight;
    logic [SIZE-1:0]  done;
    logic [DATAW-1:0] mem [SIZE];

    logic alloc_fire;
    logic rsp_accept;
    logic pop_fire;

    // Full/empty come from the count, so equal pointers are never ambiguous.
    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign alloc_ready = ~full;
    assign alloc_tag   = tail;

    assign out_valid = inflight[head] & done[head];
    assign out_tag   = head;
    assign out_data  = mem[head];

    assign alloc_fire = alloc_valid & alloc_ready;
    assign rsp_accept = rsp_valid & inflight[rsp_tag] & ~done[rsp_tag];
    assign pop_fire   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count_q  <= '0;
            inflight <= '0;
            done     <= '0;
        end else begin
            if (alloc_fire) begin
                inflight[tail] <= 1'b1;
                done[tail]     <= 1'b0;
                tail           <= tail + PTR_ONE;
            end
            if (rsp_accept) begin
                done[rsp_tag] <= 1'b1;
            end
            // Head slot is done, so it never collides with an accepted response.
            if (pop_fire) begin
                inflight[head] <= 1'b0;
                done[head]     <= 1'b0;
                head           <= head + PTR_ONE;
            end
            unique case ({alloc_fire, pop_fire})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_accept) begin
            mem[rsp_tag] <= rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rsp_valid) begin
            assert (rsp_accept)
            else $warning("dropped response for tag %0d", rsp_tag);
        end
    end

endmodule

// File: tb/tb_rv_tag_reorder_queue.sv
// Directed bench for rv_tag_reorder_queue: in-order, out-of-order,
// full/back-pressure, wrap with overlapping events, drops and reset.
module tb_rv_tag_reorder_queue;

    localparam int DATAW = 32;
    localparam int SIZE  = 8;
    localparam int ADDRW = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [ADDRW-1:0] alloc_tag;
    logic             rsp_valid;
    logic [ADDRW-1:0] rsp_tag;
    logic [DATAW-1:0] rsp_data;
    logic             out_valid;
    logic [ADDRW-1:0] out_tag;
    logic [DATAW-1:0] out_data;
    logic             out_ready;
    logic             empty;
    logic             full;
    logic [ADDRW:0]   count;

    int checks = 0;
    int errors = 0;

    rv_tag_reorder_queue #(.DATAW(DATAW), .SIZE(SIZE), .ADDRW(ADDRW)) dut (
        .clk(clk),
        .reset(reset),
        .alloc_valid(alloc_valid),
        .alloc_ready(alloc_ready),
        .alloc_tag(alloc_tag),
        .rsp_valid(rsp_valid),
        .rsp_tag(rsp_tag),
        .rsp_data(rsp_data),
        .out_valid(out_valid),
        .out_tag(out_tag),
        .out_data(out_data),
        .out_ready(out_ready),
        .empty(empty),
        .full(full),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        alloc_valid = 1'b0;
        rsp_valid   = 1'b0;
        rsp_tag     = '0;
        rsp_data    = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        alloc_valid = 1'b1;
        for (int i = 0; i < n; i++) tick();
        alloc_valid = 1'b0;
    endtask

    task automatic respond(input int tag, input logic [DATAW-1:0] d);
        rsp_valid = 1'b1;
        rsp_tag   = ADDRW'(tag);
        rsp_data  = d;
        tick();
        rsp_valid = 1'b0;
    endtask

    initial begin
        out_ready = 1'b0;
        do_reset();
        tick();

        chk("rst_ready", alloc_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_atag", alloc_tag, 0);

        // In-order flow
        out_ready   = 1'b1;
        alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("io_atag", alloc_tag, i);
            tick();
        end
        alloc_valid = 1'b0;
        chk("io_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            rsp_valid = 1'b1;
            rsp_tag   = ADDRW'(i);
            rsp_data  = 32'hA0 + i;
            chk("io_oval", out_valid, i > 0);
            if (i > 0) begin
                chk("io_otag", out_tag, i - 1);
                chk("io_odata", out_data, 32'hA0 + i - 1);
            end
            tick();
        end
        rsp_valid = 1'b0;
        chk("io_oval3", out_valid, 1);
        chk("io_otag3", out_tag, 3);
        chk("io_odata3", out_data, 32'hA3);
        tick();
        chk("io_empty", empty, 1);

        // Out-of-order returns
        do_reset();
        alloc_n(4);
        respond(3, 32'hD3);
        chk("ooo_hold3", out_valid, 0);
        respond(1, 32'hD1);
        chk("ooo_hold1", out_valid, 0);
        respond(2, 32'hD2);
        chk("ooo_hold2", out_valid, 0);
        rsp_valid = 1'b1;
        rsp_tag   = 3'd0;
        rsp_data  = 32'hD0;
        chk("ooo_same", out_valid, 0);
        tick();
        rsp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("ooo_oval", out_valid, 1);
            chk("ooo_otag", out_tag, k);
            chk("ooo_odata", out_data, 32'hD0 + k);
            tick();
        end
        chk("ooo_empty", empty, 1);

        // Full and back-pressure
        out_ready = 1'b0;
        do_reset();
        alloc_n(8);
        alloc_valid = 1'b1;
        chk("f_full", full, 1);
        chk("f_ready", alloc_ready, 0);
        chk("f_count", count, 8);
        tick();
        alloc_valid = 1'b0;
        chk("f_count9", count, 8);
        for (int i = 0; i < 8; i++) respond(i, 32'h100 + i);
        for (int c = 0; c < 3; c++) begin
            chk("bp_oval", out_valid, 1);
            chk("bp_otag", out_tag, 0);
            chk("bp_odata", out_data, 32'h100);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("bp_ptag", out_tag, i);
            chk("bp_pdata", out_data, 32'h100 + i);
            tick();
        end
        chk("bp_empty", empty, 1);
        chk("bp_count", count, 0);

        // Wrap with alloc, response and pop in the same cycles
        do_reset();
        for (int t = 0; t < 22; t++) begin
            alloc_valid = (t < 20);
            rsp_valid   = (t >= 1) && (t <= 20);
            rsp_tag     = ADDRW'((t - 1) % 8);
            rsp_data    = 32'h200 + t - 1;
            if (t < 20) chk("w_atag", alloc_tag, t % 8);
            chk("w_count", count,
                (t == 0) ? 0 : ((t == 1 || t == 21) ? 1 : 2));
            chk("w_oval", out_valid, (t >= 2) && (t <= 21));
            if (t >= 2) begin
                chk("w_otag", out_tag, (t - 2) % 8);
                chk("w_odata", out_data, 32'h200 + t - 2);
            end
            tick();
        end
        alloc_valid = 1'b0;
        rsp_valid   = 1'b0;
        chk("w_empty", empty, 1);

        // Dropped responses: non-inflight tag and repeat to a done tag
        out_ready = 1'b0;
        chk("d_atag", alloc_tag, 4);
        alloc_n(1);
        respond(4, 32'h4444);
        respond(5, 32'hBAD);
        chk("d_odata5", out_data, 32'h4444);
        chk("d_count", count, 1);
        respond(4, 32'hBAD);
        chk("d_odata4", out_data, 32'h4444);
        out_ready = 1'b1;
        tick();
        chk("d_empty", empty, 1);
        alloc_n(1);
        chk("d_otag5", out_tag, 5);
        chk("d_oval5", out_valid, 0);

        // Reset with outstanding tags
        out_ready = 1'b0;
        do_reset();
        alloc_n(5);
        respond(0, 32'h50);
        respond(2, 32'h52);
        chk("r_count5", count, 5);
        chk("r_oval1", out_valid, 1);
        do_reset();
        chk("r_count0", count, 0);
        chk("r_oval0", out_valid, 0);
        chk("r_empty", empty, 1);
        respond(2, 32'h99);
        chk("r_count_drop", count, 0);
        chk("r_oval_drop", out_valid, 0);
        alloc_n(3);
        chk("r_oval_re", out_valid, 0);
        chk("r_count3", count, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
